// File: rtl/seg_scan_ctrl_if.sv
// Scan controller bus: display enable and digit mask in,
// digit select, anodes and scan pulses out.
interface seg_scan_ctrl_if;
  logic       en;
  logic [7:0] digit_mask;
  logic [2:0] sel;
  logic [7:0] an;
  logic       scan_tick;
  logic       frame_done;

  modport master (
    output en,
    output digit_mask,
    input  sel,
    input  an,
    input  scan_tick,
    input  frame_done
  );

  modport slave (
    input  en,
    input  digit_mask,
    output sel,
    output an,
    output scan_tick,
    output frame_done
  );
endinterface

// File: rtl/seg_scan_ctrl.sv
// Eight-digit seven-segment scan controller with a blanking
// interval ahead of every digit to suppress ghosting.
module seg_scan_ctrl #(
  parameter int TICKS_ON    = 100000,
  parameter int TICKS_BLANK = 1000,
  parameter int CNT_W       = 17
) (
  input  logic           clk,
  input  logic           reset,
  seg_scan_ctrl_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    BLANK = 2'd1,
    ON    = 2'd2
  } state_t;

  localparam logic [CNT_W-1:0] ON_LAST =
    CNT_W'(TICKS_ON - 1);
  localparam logic [CNT_W-1:0] BLANK_LAST =
    CNT_W'(TICKS_BLANK - 1);

  state_t           state;
  state_t           state_nx;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] cnt_nx;
  logic [2:0]       sel;
  logic [2:0]       sel_nx;
  logic [7:0]       an;
  logic [7:0]       an_nx;
  logic             tick;
  logic             tick_nx;
  logic             frame;
  logic             frame_nx;

  logic             scanning;
  logic             in_idle;
  logic             drop;
  logic             blank_end;
  logic             on_end;
  logic [7:0]       onehot;

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      cnt   <= '0;
      sel   <= '0;
      an    <= 8'hFF;
      tick  <= 1'b0;
      frame <= 1'b0;
    end else begin
      state <= state_nx;
      cnt   <= cnt_nx;
      sel   <= sel_nx;
      an    <= an_nx;
      tick  <= tick_nx;
      frame <= frame_nx;
    end
  end

  // An unreachable encoding is treated like a dropped enable.
  assign scanning  = (state == BLANK) || (state == ON);
  assign in_idle   = (state == IDLE);
  assign drop      = !in_idle && (!bus.en || !scanning);
  assign blank_end = (state == BLANK) && bus.en
                     && (cnt == BLANK_LAST);
  assign on_end    = (state == ON) && bus.en
                     && (cnt == ON_LAST);

  always_comb begin
    state_nx = state;
    cnt_nx   = cnt + 1'b1;
    sel_nx   = sel;
    unique case (1'b1)
      in_idle: begin
        cnt_nx   = '0;
        sel_nx   = '0;
        state_nx = bus.en ? BLANK : IDLE;
      end
      drop: begin
        state_nx = IDLE;
        cnt_nx   = '0;
        sel_nx   = '0;
      end
      blank_end: begin
        state_nx = ON;
        cnt_nx   = '0;
      end
      on_end: begin
        state_nx = BLANK;
        cnt_nx   = '0;
        sel_nx   = sel + 3'd1;
      end
      default: ;
    endcase
  end

  always_comb begin
    onehot   = 8'd1 << sel_nx;
    an_nx    = 8'hFF;
    tick_nx  = on_end;
    frame_nx = on_end && (sel == 3'd7);
    if (state_nx == ON)
      an_nx = ~(onehot & bus.digit_mask);
  end

  assign bus.sel        = sel;
  assign bus.an         = an;
  assign bus.scan_tick  = tick;
  assign bus.frame_done = frame;

endmodule

// File: tb/tb_seg_scan_ctrl.sv
// Directed bench for seg_scan_ctrl with 4-cycle digits
// and 2-cycle blanking; 48-cycle frames.
module tb_seg_scan_ctrl;

  logic clk;
  logic reset;
  int   checks;
  int   errors;

  seg_scan_ctrl_if bus ();

  seg_scan_ctrl #(
    .TICKS_ON    (4),
    .TICKS_BLANK (2),
    .CNT_W       (3)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(
    input string       tag,
    input logic [31:0] got,
    input logic [31:0] exp
  );
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h",
               tag, got, exp);
    end
  endtask

  task automatic expect_out(
    input string      tag,
    input logic [2:0] s,
    input logic [7:0] a,
    input logic       t,
    input logic       f
  );
    check({tag, ".sel"}, 32'(bus.sel), 32'(s));
    check({tag, ".an"}, 32'(bus.an), 32'(a));
    check({tag, ".tick"}, 32'(bus.scan_tick), 32'(t));
    check({tag, ".frame"}, 32'(bus.frame_done), 32'(f));
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Starts just after the slot-0 first blanking cycle,
  // ends on the edge where sel wraps 7->0.
  task automatic run_frame(input logic [7:0] m);
    logic [7:0] a;
    string      tag;
    for (int d = 0; d < 8; d++) begin
      for (int c = 0; c < 6; c++) begin
        if (d == 0 && c == 0) continue;
        step();
        a = 8'd1 << d;
        a = (c < 2 || !m[d]) ? 8'hFF : ~a;
        tag = $sformatf("m%0h_d%0d_c%0d", m, d, c);
        expect_out(tag, 3'(d), a, c == 0, 1'b0);
      end
    end
    step();
    expect_out($sformatf("m%0h_wrap", m),
               3'd0, 8'hFF, 1'b1, 1'b1);
  endtask

  initial begin
    checks         = 0;
    errors         = 0;
    reset          = 1'b1;
    bus.en         = 1'b1;
    bus.digit_mask = 8'hFF;

    for (int i = 0; i < 3; i++) begin
      step();
      expect_out("rst", 3'd0, 8'hFF, 1'b0, 1'b0);
    end

    reset = 1'b0;
    step();
    expect_out("start", 3'd0, 8'hFF, 1'b0, 1'b0);
    run_frame(8'hFF);

    bus.digit_mask = 8'h05;
    run_frame(8'h05);

    bus.digit_mask = 8'hFF;
    repeat (32) step();
    expect_out("d5_on", 3'd5, 8'hDF, 1'b0, 1'b0);
    repeat (3) step();
    expect_out("d5_last", 3'd5, 8'hDF, 1'b0, 1'b0);
    bus.en = 1'b0;
    step();
    expect_out("en_drop", 3'd0, 8'hFF, 1'b0, 1'b0);
    step();
    expect_out("en_idle", 3'd0, 8'hFF, 1'b0, 1'b0);
    bus.en = 1'b1;
    step();
    expect_out("re_blank0", 3'd0, 8'hFF, 1'b0, 1'b0);
    step();
    expect_out("re_blank1", 3'd0, 8'hFF, 1'b0, 1'b0);
    step();
    expect_out("re_on", 3'd0, 8'hFE, 1'b0, 1'b0);

    repeat (19) step();
    expect_out("d3_on", 3'd3, 8'hF7, 1'b0, 1'b0);
    reset = 1'b1;
    step();
    expect_out("mid_rst", 3'd0, 8'hFF, 1'b0, 1'b0);
    reset = 1'b0;
    step();
    expect_out("rs_blank0", 3'd0, 8'hFF, 1'b0, 1'b0);
    step();
    expect_out("rs_blank1", 3'd0, 8'hFF, 1'b0, 1'b0);
    step();
    expect_out("rs_on", 3'd0, 8'hFE, 1'b0, 1'b0);

    repeat (7) step();
    expect_out("d1_on", 3'd1, 8'hFD, 1'b0, 1'b0);
    bus.digit_mask = 8'hFD;
    step();
    expect_out("d1_masked", 3'd1, 8'hFF, 1'b0, 1'b0);
    step();
    expect_out("d1_slot_end", 3'd1, 8'hFF, 1'b0, 1'b0);
    step();
    expect_out("d2_tick", 3'd2, 8'hFF, 1'b1, 1'b0);
    step();
    expect_out("d2_blank1", 3'd2, 8'hFF, 1'b0, 1'b0);
    step();
    expect_out("d2_on", 3'd2, 8'hFB, 1'b0, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
